// File: rtl/pmem_line_arbiter.sv
// Arbitrates one physical-memory line port between demand and prefetch; demand wins unless prefetch has aged out.
// Grant is visible on pmem_* one cycle after the request; requesters hold their level request until resp (no other backpressure).
module pmem_line_arbiter #(
  parameter int WIDTH   = 256,
  parameter int AGE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dem_read,
  input  logic             dem_write,
  input  logic [31:0]      dem_address,
  input  logic [WIDTH-1:0] dem_wdata,
  output logic [WIDTH-1:0] dem_rdata,
  output logic             dem_resp,
  input  logic             pf_read,
  input  logic [31:0]      pf_address,
  output logic [WIDTH-1:0] pf_rdata,
  output logic             pf_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [31:0]      pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  localparam int AW = $clog2(AGE_MAX + 1);
  localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

  typedef enum logic [1:0] {IDLE, DEM_BUSY, PF_BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    age_q, age_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] line_q, line_d;
  logic             dem_resp_q, dem_resp_d;
  logic             pf_resp_q, pf_resp_d;
  logic             dem_req;

  assign dem_req = dem_read | dem_write;

  always_comb begin
    state_d    = state_q;
    age_d      = age_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    dem_resp_d = 1'b0;
    pf_resp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // An aged-out prefetch overrides demand priority.
        if (pf_read && (age_q == AGE_LIM || !dem_req)) begin
          state_d = PF_BUSY;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = pf_address;
          age_d   = '0;
        end else if (dem_req) begin
          state_d = DEM_BUSY;
          wr_d    = dem_write;
          rd_d    = !dem_write;
          addr_d  = dem_address;
          wdata_d = dem_wdata;
          if (!pf_read) begin
            age_d = '0;
          end else if (age_q != AGE_LIM) begin
            age_d = age_q + AW'(1);
          end
        end else begin
          age_d = '0;
        end
      end
      DEM_BUSY, PF_BUSY: begin
        if (pmem_resp) begin
          state_d    = DONE;
          line_d     = pmem_rdata;
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          dem_resp_d = (state_q == DEM_BUSY);
          pf_resp_d  = (state_q == PF_BUSY);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      age_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      dem_resp_q <= 1'b0;
      pf_resp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
      dem_resp_q <= dem_resp_d;
      pf_resp_q  <= pf_resp_d;
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign dem_rdata    = line_q;
  assign pf_rdata     = line_q;
  assign dem_resp     = dem_resp_q;
  assign pf_resp      = pf_resp_q;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Bench for pmem_line_arbiter: directed vector table, hand sequences for aging and reset, then random traffic vs a rule model.
module tb_pmem_line_arbiter;
  localparam int W  = 256;
  localparam int AM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          dem_read, dem_write, pf_read, pmem_resp;
  logic [31:0]   dem_address, pf_address;
  logic [W-1:0]  dem_wdata, pmem_rdata;
  logic [W-1:0]  dem_rdata, pf_rdata, pmem_wdata;
  logic          dem_resp, pf_resp, pmem_read, pmem_write;
  logic [31:0]   pmem_address;

  always #5 clk = ~clk;

  pmem_line_arbiter #(.WIDTH(W), .AGE_MAX(AM)) dut (
    .clk(clk), .reset(reset),
    .dem_read(dem_read), .dem_write(dem_write), .dem_address(dem_address),
    .dem_wdata(dem_wdata), .dem_rdata(dem_rdata), .dem_resp(dem_resp),
    .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: phase 0 idle, 1 demand owns memory, 2 prefetch owns memory, 3 completion cycle.
  int           m_ph  = 0;
  int           m_age = 0;
  logic         m_rd = 1'b0, m_wr = 1'b0, m_dresp = 1'b0, m_presp = 1'b0;
  logic [31:0]  m_addr = '0;
  logic [W-1:0] m_wdata = '0, m_line = '0;

  task automatic model_step();
    logic dreq;
    dreq    = dem_read | dem_write;
    m_dresp = 1'b0;
    m_presp = 1'b0;
    if (reset) begin
      m_ph = 0; m_age = 0; m_rd = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_line = '0;
    end else if (m_ph == 0) begin
      if (pf_read && (m_age == AM || !dreq)) begin
        m_ph = 2; m_rd = 1'b1; m_wr = 1'b0; m_addr = pf_address; m_age = 0;
      end else if (dreq) begin
        m_ph = 1; m_wr = dem_write; m_rd = !dem_write;
        m_addr = dem_address; m_wdata = dem_wdata;
        m_age = pf_read ? ((m_age + 1 > AM) ? AM : m_age + 1) : 0;
      end else begin
        m_age = 0;
      end
    end else if (m_ph == 3) begin
      m_ph = 0;
    end else if (pmem_resp) begin
      m_line = pmem_rdata; m_rd = 1'b0; m_wr = 1'b0;
      m_dresp = (m_ph == 1); m_presp = (m_ph == 2); m_ph = 3;
    end
  endtask

  task automatic model_check();
    chk("m_pmem_read",  W'(pmem_read),    W'(m_rd));
    chk("m_pmem_write", W'(pmem_write),   W'(m_wr));
    chk("m_pmem_addr",  W'(pmem_address), W'(m_addr));
    chk("m_dem_resp",   W'(dem_resp),     W'(m_dresp));
    chk("m_pf_resp",    W'(pf_resp),      W'(m_presp));
    chk("m_dem_rdata",  dem_rdata,        m_line);
    chk("m_pf_rdata",   pf_rdata,         m_line);
    chk("m_age",        W'(dut.age_q),    W'(m_age));
    if (m_wr) chk("m_pmem_wdata", pmem_wdata, m_wdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    model_check();
  endtask

  typedef struct {
    logic [4:0]  in_ctl;   // {reset, dem_read, dem_write, pf_read, pmem_resp}
    logic [31:0] da, pa, rd32;
    logic [3:0]  e_ctl;    // {pmem_read, pmem_write, dem_resp, pf_resp}
    logic [31:0] e_addr, e_rd32;
  } vec_t;

  vec_t tbl[18];
  logic [W-1:0] a5;

  initial begin
    reset = 1'b1; dem_read = 1'b0; dem_write = 1'b0; pf_read = 1'b0; pmem_resp = 1'b0;
    dem_address = '0; pf_address = '0; pmem_rdata = '0;
    a5 = {32{8'hA5}};
    dem_wdata = a5;

    tbl[0]  = '{5'b10000, 32'h0,   32'h0,   32'h0,        4'b0000, 32'h0,   32'h0};
    tbl[1]  = '{5'b00001, 32'h0,   32'h0,   32'hDEADBEEF, 4'b0000, 32'h0,   32'h0};
    tbl[2]  = '{5'b00000, 32'h0,   32'h0,   32'h0,        4'b0000, 32'h0,   32'h0};
    tbl[3]  = '{5'b01000, 32'h100, 32'h0,   32'h0,        4'b1000, 32'h100, 32'h0};
    tbl[4]  = '{5'b01000, 32'h100, 32'h0,   32'h0,        4'b1000, 32'h100, 32'h0};
    tbl[5]  = '{5'b01000, 32'h100, 32'h0,   32'h0,        4'b1000, 32'h100, 32'h0};
    tbl[6]  = '{5'b01001, 32'h100, 32'h0,   32'h11111111, 4'b0010, 32'h0,   32'h11111111};
    tbl[7]  = '{5'b00000, 32'h100, 32'h0,   32'h0,        4'b0000, 32'h0,   32'h0};
    tbl[8]  = '{5'b01010, 32'h200, 32'h300, 32'h0,        4'b1000, 32'h200, 32'h0};
    tbl[9]  = '{5'b01011, 32'h200, 32'h300, 32'h22222222, 4'b0010, 32'h0,   32'h22222222};
    tbl[10] = '{5'b00010, 32'h200, 32'h300, 32'h0,        4'b0000, 32'h0,   32'h0};
    tbl[11] = '{5'b00010, 32'h200, 32'h300, 32'h0,        4'b1000, 32'h300, 32'h0};
    tbl[12] = '{5'b00011, 32'h200, 32'h300, 32'h33333333, 4'b0001, 32'h0,   32'h33333333};
    tbl[13] = '{5'b00000, 32'h200, 32'h300, 32'h0,        4'b0000, 32'h0,   32'h0};
    tbl[14] = '{5'b01100, 32'h400, 32'h0,   32'h0,        4'b0100, 32'h400, 32'h0};
    tbl[15] = '{5'b01101, 32'h400, 32'h0,   32'h0,        4'b0010, 32'h0,   32'h0};
    tbl[16] = '{5'b00000, 32'h400, 32'h0,   32'h0,        4'b0000, 32'h0,   32'h0};
    tbl[17] = '{5'b00001, 32'h400, 32'h0,   32'h5555,     4'b0000, 32'h0,   32'h0};

    for (int i = 0; i < 18; i++) begin
      {reset, dem_read, dem_write, pf_read, pmem_resp} = tbl[i].in_ctl;
      dem_address = tbl[i].da;
      pf_address  = tbl[i].pa;
      pmem_rdata  = {8{tbl[i].rd32}};
      step();
      chk($sformatf("v%0d_pmem_read", i),  W'(pmem_read),  W'(tbl[i].e_ctl[3]));
      chk($sformatf("v%0d_pmem_write", i), W'(pmem_write), W'(tbl[i].e_ctl[2]));
      chk($sformatf("v%0d_dem_resp", i),   W'(dem_resp),   W'(tbl[i].e_ctl[1]));
      chk($sformatf("v%0d_pf_resp", i),    W'(pf_resp),    W'(tbl[i].e_ctl[0]));
      if (tbl[i].e_ctl[3] || tbl[i].e_ctl[2])
        chk($sformatf("v%0d_pmem_addr", i), W'(pmem_address), W'(tbl[i].e_addr));
      if (tbl[i].e_ctl[2])
        chk($sformatf("v%0d_pmem_wdata", i), pmem_wdata, a5);
      if (tbl[i].e_ctl[1])
        chk($sformatf("v%0d_dem_rdata", i), dem_rdata, {8{tbl[i].e_rd32}});
      if (tbl[i].e_ctl[0])
        chk($sformatf("v%0d_pf_rdata", i), pf_rdata, {8{tbl[i].e_rd32}});
    end
    reset = 1'b0; dem_read = 1'b0; dem_write = 1'b0; pf_read = 1'b0; pmem_resp = 1'b0;

    // Prefetch held while demand re-requests: the fifth grant must go to prefetch.
    dem_address = 32'h1000; pf_address = 32'h2000;
    step();
    for (int g = 0; g < 5; g++) begin
      dem_read = 1'b1; pf_read = 1'b1;
      step();
      chk($sformatf("t3_g%0d_addr", g), W'(pmem_address), W'((g < 4) ? 32'h1000 : 32'h2000));
      if (g == 3) chk("t3_age_sat", W'(dut.age_q), W'(AM));
      if (g == 4) chk("t3_age_clr", W'(dut.age_q), W'(0));
      pmem_resp = 1'b1; pmem_rdata = rnd256();
      step();
      pmem_resp = 1'b0;
      chk($sformatf("t3_g%0d_dem_resp", g), W'(dem_resp), W'(g < 4));
      chk($sformatf("t3_g%0d_pf_resp", g),  W'(pf_resp),  W'(g == 4));
      chk($sformatf("t3_g%0d_rdata", g), (g < 4) ? dem_rdata : pf_rdata, pmem_rdata);
      dem_read = 1'b0; pf_read = (g < 4);
      step();
    end

    // Reset during a prefetch transfer, then a stray memory completion.
    pf_read = 1'b1; pf_address = 32'h3000;
    step();
    chk("t5_pf_grant", W'(pmem_read), W'(1));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rd_after_rst", W'(pmem_read), W'(0));
    pf_read = 1'b0; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk("t5_no_pf_resp", W'(pf_resp), W'(0));
    chk("t5_no_read", W'(pmem_read), W'(0));
    step();
    chk("t5_idle_addr", W'(pmem_address), W'(0));

    // Random traffic with variable memory latency, stray completions and occasional reset.
    begin
      int mem_cnt;
      logic mem_busy;
      mem_cnt = 0; mem_busy = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        reset = ($urandom_range(299) == 0);
        if (dem_read || dem_write) begin
          if (dem_resp) begin dem_read = 1'b0; dem_write = 1'b0; end
        end else if ($urandom_range(3) == 0) begin
          dem_read    = $urandom_range(1);
          dem_write   = !dem_read || ($urandom_range(3) == 0);
          dem_address = $urandom;
          dem_wdata   = rnd256();
        end
        if (pf_read) begin
          if (pf_resp) pf_read = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          pf_read    = 1'b1;
          pf_address = $urandom;
        end
        pmem_resp  = 1'b0;
        pmem_rdata = rnd256();
        if (pmem_read || pmem_write) begin
          if (!mem_busy) begin mem_busy = 1'b1; mem_cnt = $urandom_range(3); end
          if (mem_cnt == 0) begin pmem_resp = 1'b1; mem_busy = 1'b0; end
          else mem_cnt--;
        end else begin
          mem_busy  = 1'b0;
          pmem_resp = ($urandom_range(15) == 0);
        end
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
